// File: rtl/mand_iter_core.sv
// -----------------------------------------------------------------------------
// mand_iter_core
//
// Escape-time iterator for z <- z^2 + c in signed fixed point (Q INT.FRAC).
// One request is held at a time: it is accepted in IDLE, iterated one step per
// clock in RUN and presented in DONE until the consumer takes it.
//
// Mandelbrot mode starts from z0 = c = pixel; Julia mode starts from z0 = pixel
// with c = k. Each request carries its own iteration limit and an ID tag that
// is returned unchanged with the result.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   in_re, in_im        pixel coordinate, W = INT_BITS+FRAC_BITS bits each
//   in_julia            0: Mandelbrot, 1: Julia
//   k_re, k_im          Julia constant
//   max_iter            iteration limit for this request
//   in_id               tag returned with the result
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   out_iter            escape iteration, or max_iter when the limit was hit
//   out_div             1 = escaped (|z|^2 > 4.0), 0 = limit reached
//   out_id              tag of the request
// -----------------------------------------------------------------------------
module mand_iter_core #(
  parameter int INT_BITS  = 4,
  parameter int FRAC_BITS = 23,
  parameter int ITER_W    = 16,
  parameter int ID_W      = 16,
  localparam int W        = INT_BITS + FRAC_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic                in_julia,
  input  logic signed [W-1:0] k_re,
  input  logic signed [W-1:0] k_im,
  input  logic [ITER_W-1:0]   max_iter,
  input  logic [ID_W-1:0]     in_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_div,
  output logic [ID_W-1:0]     out_id
);

  // 4.0 expressed at the scale of a full-width square (2*FRAC_BITS fraction
  // bits), held in the 2W+1-bit magnitude width.
  localparam logic signed [2*W:0] MAG_LIMIT =
    {{(2*W-2*FRAC_BITS-2){1'b0}}, 3'b100, {(2*FRAC_BITS){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;

  // Iteration state
  logic signed [W-1:0] z_re;
  logic signed [W-1:0] z_im;
  logic signed [W-1:0] c_re;
  logic signed [W-1:0] c_im;
  logic [ITER_W-1:0]   count;
  logic [ITER_W-1:0]   max_q;
  logic [ID_W-1:0]     id_q;

  // Sign-extend a W-bit value to 2W bits so products are formed at full width.
  function automatic logic signed [2*W-1:0] widen(input logic signed [W-1:0] v);
    return $signed({{W{v[W-1]}}, v});
  endfunction

  // Sign-extend a 2W-bit product to the 2W+1-bit sum/difference width.
  function automatic logic signed [2*W:0] widen1(input logic signed [2*W-1:0] v);
    return $signed({v[2*W-1], v});
  endfunction

  // Drop the extra FRAC_BITS of a product-scale value: arithmetic shift
  // (floor toward -inf), then truncate to W bits. No saturation is needed
  // because the update only runs while |z| <= 2, so the result stays in range.
  function automatic logic signed [W-1:0] rescale(input logic signed [2*W:0] v);
    logic signed [2*W:0] s;
    s = v >>> FRAC_BITS;
    return $signed(s[W-1:0]);
  endfunction

  // ---- stage p0: full-width products and magnitude of the current z ----
  logic signed [2*W-1:0] zre_p0;
  logic signed [2*W-1:0] zim_p0;
  logic signed [2*W-1:0] re2_p0;
  logic signed [2*W-1:0] im2_p0;
  logic signed [2*W-1:0] x_p0;
  logic signed [2*W:0]   mag_p0;
  logic signed [2*W:0]   diff_p0;
  logic signed [2*W:0]   dbl_p0;
  logic signed [W-1:0]   zre_next_p0;
  logic signed [W-1:0]   zim_next_p0;
  logic                  esc_p0;
  logic                  lim_p0;

  assign zre_p0  = widen(z_re);
  assign zim_p0  = widen(z_im);
  // Low 2W bits of a 2W x 2W product are exact: |z| components are below 8.
  assign re2_p0  = zre_p0 * zre_p0;
  assign im2_p0  = zim_p0 * zim_p0;
  assign x_p0    = zre_p0 * zim_p0;
  assign mag_p0  = widen1(re2_p0) + widen1(im2_p0);
  assign diff_p0 = widen1(re2_p0) - widen1(im2_p0);
  assign dbl_p0  = widen1(x_p0) <<< 1;

  assign zre_next_p0 = rescale(diff_p0) + c_re;
  assign zim_next_p0 = rescale(dbl_p0) + c_im;

  // Divergence has priority over the limit when both hold in one cycle.
  assign esc_p0 = (mag_p0 > MAG_LIMIT);
  assign lim_p0 = (count == max_q);

  // ---- stage p1: FSM, iteration state and registered result ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_iter  <= '0;
      out_div   <= 1'b0;
      out_id    <= '0;
      count     <= '0;
      z_re      <= '0;
      z_im      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is registered high whenever the core sits in IDLE
          if (in_valid) begin
            z_re     <= in_re;
            z_im     <= in_im;
            c_re     <= in_julia ? k_re : in_re;
            c_im     <= in_julia ? k_im : in_im;
            max_q    <= max_iter;
            id_q     <= in_id;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          if (esc_p0 || lim_p0) begin
            out_iter  <= count;
            out_div   <= esc_p0;
            out_id    <= id_q;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            z_re  <= zre_next_p0;
            z_im  <= zim_next_p0;
            count <= count + 1'b1;
          end
        end

        S_DONE: begin
          // in_ready rises together with the return to IDLE, so a new request
          // is never taken in the same cycle the result leaves.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Result stays put while the consumer stalls.
  assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_iter) &&
                                   $stable(out_div) && $stable(out_id)));

  // The two handshakes are never offered at the same time.
  assert property (@(posedge clock) disable iff (reset)
    !(in_ready && out_valid));

endmodule

// File: tb/tb_mand_iter_core.sv
// -----------------------------------------------------------------------------
// tb_mand_iter_core
//
// Directed bench for mand_iter_core at default parameters. A table of requests
// with hand-computed escape iteration, divergence flag and latency is applied
// in a loop; backpressure and reset-in-RUN are exercised as separate sequences.
// -----------------------------------------------------------------------------
module tb_mand_iter_core;

  localparam int INT_BITS  = 4;
  localparam int FRAC_BITS = 23;
  localparam int ITER_W    = 16;
  localparam int ID_W      = 16;
  localparam int W         = INT_BITS + FRAC_BITS;
  localparam int ONE       = 1 << FRAC_BITS;
  localparam int BUDGET    = 400;

  typedef struct {
    logic                julia;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic signed [W-1:0] kre;
    logic signed [W-1:0] kim;
    logic [ITER_W-1:0]   max_iter;
    logic [ID_W-1:0]     id;
    logic [ITER_W-1:0]   exp_iter;
    logic                exp_div;
  } vec_t;

  logic                clock;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                in_julia;
  logic signed [W-1:0] k_re;
  logic signed [W-1:0] k_im;
  logic [ITER_W-1:0]   max_iter;
  logic [ID_W-1:0]     in_id;
  logic                out_valid;
  logic                out_ready;
  logic [ITER_W-1:0]   out_iter;
  logic                out_div;
  logic [ID_W-1:0]     out_id;

  int checks = 0;
  int fails  = 0;

  vec_t vecs[11];

  mand_iter_core #(
    .INT_BITS (INT_BITS),
    .FRAC_BITS(FRAC_BITS),
    .ITER_W   (ITER_W),
    .ID_W     (ID_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .in_julia (in_julia),
    .k_re     (k_re),
    .k_im     (k_im),
    .max_iter (max_iter),
    .in_id    (in_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_iter (out_iter),
    .out_div  (out_div),
    .out_id   (out_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic signed [W-1:0] fx(input int v);
    return W'(v);
  endfunction

  function automatic vec_t mk(input logic j, input int re, input int im,
                              input int kre, input int kim, input int mx,
                              input int id, input int ei, input logic ed);
    vec_t v;
    v.julia    = j;
    v.re       = fx(re);
    v.im       = fx(im);
    v.kre      = fx(kre);
    v.kim      = fx(kim);
    v.max_iter = ITER_W'(mx);
    v.id       = ID_W'(id);
    v.exp_iter = ITER_W'(ei);
    v.exp_div  = ed;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    in_re    = v.re;
    in_im    = v.im;
    in_julia = v.julia;
    k_re     = v.kre;
    k_im     = v.kim;
    max_iter = v.max_iter;
    in_id    = v.id;
    in_valid = 1'b1;
  endtask

  // Issue one request, wait for the result, hold it for 'hold' stalled cycles,
  // then release it and confirm the return to IDLE.
  task automatic run_vec(input vec_t v, input int hold);
    int cyc;
    @(negedge clock);
    drive_req(v);
    check("in_ready before accept", longint'(in_ready), 1);
    @(negedge clock);
    in_valid = 1'b0;
    in_re    = fx(5 * ONE);   // inputs must not be resampled after accept
    k_re     = fx(7 * ONE);
    cyc      = 1;
    check("in_ready in RUN", longint'(in_ready), 0);
    while (!out_valid && cyc < BUDGET) begin
      @(negedge clock);
      cyc++;
    end
    check("out_valid arrives", longint'(out_valid), 1);
    check("latency", longint'(cyc), longint'(v.exp_iter) + 2);
    check("out_iter", longint'(out_iter), longint'(v.exp_iter));
    check("out_div", longint'(out_div), longint'(v.exp_div));
    check("out_id", longint'(out_id), longint'(v.id));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;        // offered request must not be taken in DONE
      in_id    = ~v.id;
      @(negedge clock);
      check("stall out_valid", longint'(out_valid), 1);
      check("stall in_ready", longint'(in_ready), 0);
      check("stall out_iter", longint'(out_iter), longint'(v.exp_iter));
      check("stall out_div", longint'(out_div), longint'(v.exp_div));
      check("stall out_id", longint'(out_id), longint'(v.id));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("out_valid after release", longint'(out_valid), 0);
    check("in_ready after release", longint'(in_ready), 1);
  endtask

  initial begin
    int seen_valid;

    // Mandelbrot: c = 0 stays at 0 and hits the limit.
    vecs[0]  = mk(1'b0, 0, 0, 0, 0, 100, 16'h0101, 100, 1'b0);
    // c = 1+1j: |z0|^2 = 2, z1 = 1+3j -> |z1|^2 = 10.
    vecs[1]  = mk(1'b0, ONE, ONE, 0, 0, 100, 16'h0202, 1, 1'b1);
    // c = -2: z stays at 2, |z|^2 exactly 4 never counts as escape.
    vecs[2]  = mk(1'b0, -2 * ONE, 0, 0, 0, 50, 16'h0303, 50, 1'b0);
    // Julia k = 0, z0 = 1.5: z1 = 2.25 escapes.
    vecs[3]  = mk(1'b1, (3 * ONE) / 2, 0, 0, 0, 20, 16'h0404, 1, 1'b1);
    // Julia k = 0, z0 = 0.5: shrinks toward 0.
    vecs[4]  = mk(1'b1, ONE / 2, 0, 0, 0, 37, 16'h0505, 37, 1'b0);
    // max_iter = 0 tests only z0.
    vecs[5]  = mk(1'b0, 0, 0, 0, 0, 0, 16'h0606, 0, 1'b0);
    // c = 3: escapes on z0 itself.
    vecs[6]  = mk(1'b0, 3 * ONE, 0, 0, 0, 10, 16'h0707, 0, 1'b1);
    // c = 2j: z1 = -4+2j (negative real part after the shift).
    vecs[7]  = mk(1'b0, 0, 2 * ONE, 0, 0, 10, 16'h0808, 1, 1'b1);
    // c = 1-1j: z1 = 1-3j, needs the signed cross term.
    vecs[8]  = mk(1'b0, ONE, -ONE, 0, 0, 10, 16'h0909, 1, 1'b1);
    // Mandelbrot c = 1: 0->1->2->5, escapes at count 2.
    vecs[9]  = mk(1'b0, ONE, 0, 0, 0, 20, 16'h0a0a, 2, 1'b1);
    // Julia z0 = 0, k = 1: 0->1->2->5, escapes at count 3.
    vecs[10] = mk(1'b1, 0, 0, ONE, 0, 20, 16'h0b0b, 3, 1'b1);

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_julia  = 1'b0;
    k_re      = '0;
    k_im      = '0;
    max_iter  = '0;
    in_id     = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_iter", longint'(out_iter), 0);
    check("reset out_div", longint'(out_div), 0);
    check("reset out_id", longint'(out_id), 0);

    // out_ready while nothing is pending has no effect.
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("idle out_ready ignored", longint'(out_valid), 0);
    out_ready = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], 0);

    // Backpressure: hold the result for 10 cycles.
    run_vec(vecs[1], 10);

    // Reset in the middle of a long run: no result may appear.
    @(negedge clock);
    drive_req(vecs[0]);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (19) @(negedge clock);
    check("pre-reset still running", longint'(in_ready), 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid-run reset in_ready", longint'(in_ready), 1);
    check("mid-run reset out_valid", longint'(out_valid), 0);
    check("mid-run reset out_iter", longint'(out_iter), 0);
    check("mid-run reset out_div", longint'(out_div), 0);
    check("mid-run reset out_id", longint'(out_id), 0);
    seen_valid = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (out_valid) seen_valid++;
    end
    check("no result after reset", longint'(seen_valid), 0);
    check("idle after reset", longint'(in_ready), 1);

    // Next request after the abandoned one is handled normally.
    run_vec(vecs[9], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
